repairmb_lane_evaluator: RTL
============================

Name: repairmb_lane_evaluator

Overview:
Upstream stage of the RepairMB functional-lane checker in MBINIT. Accumulates per-lane compare errors from the Rx data-to-clock point test, thresholds each lane, and encodes the result as the 2-bit functional-lane code: 11 = all 16 lanes good, 01 = lanes 0-7 only, 10 = lanes 8-15 only, 00 = none. It then drives the checker's start/second-check handshake and waits for its done, with a timeout guard.

Parameters:
NUM_LANES, 16, data lanes evaluated; must be even; lower half = lanes [NUM_LANES/2-1:0].
CNT_W, 8, width of each per-lane saturating error counter.
ERR_THRESHOLD, 4, maximum error count at which a lane still passes (pass if count <= threshold).
TIMEOUT_CYC, 1024, cycles allowed in CHECK before timeout.

Ports:
CLK  input  1  block clock.
rst_n  input  1  asynchronous active-low reset.
i_start_eval  input  1  one-cycle pulse; starts an evaluation pass.
i_second_pass  input  1  sampled with i_start_eval; 1 = re-evaluation after degrade/repeat.
i_lane_err_valid  input  1  i_lane_err is valid this cycle.
i_lane_err  input  NUM_LANES  per-lane mismatch flags, 1 = error on that lane this cycle.
i_pattern_done  input  1  pulse; test pattern complete.
i_done_check  input  1  done from the functional-lane checker.
i_abort  input  1  synchronous abort; returns to IDLE from any state.
o_Functional_Lanes  output  2  encoded functional-lane result to the checker.
o_lane_pass  output  NUM_LANES  per-lane pass vector.
o_start_check  output  1  level; start request to the checker.
o_second_check  output  1  level; second-check qualifier to the checker.
o_busy  output  1  high in every state except IDLE.
o_timeout  output  1  one-cycle pulse on CHECK timeout.

Behaviour:
- Reset: state IDLE. Counters 0. o_Functional_Lanes = 00, o_lane_pass = 0, o_start_check = 0, o_second_check = 0, o_busy = 0, o_timeout = 0.
- FSM states: IDLE, ACCUM, EVAL, CHECK.
- IDLE: on i_start_eval, clear all counters, latch i_second_pass into second_r, go to ACCUM. Other inputs are ignored.
- ACCUM: on each cycle with i_lane_err_valid, counter[i] increments for every set i_lane_err[i]. Counters saturate at 2^CNT_W-1 and never wrap.
  - On i_pattern_done, go to EVAL. A valid error sample in the same cycle as i_pattern_done is counted.
  - i_start_eval in ACCUM is ignored; no restart.
- EVAL (1 cycle): o_lane_pass[i] <= (counter[i] <= ERR_THRESHOLD).
  - o_Functional_Lanes[0] <= AND of the lower-half pass bits; o_Functional_Lanes[1] <= AND of the upper-half pass bits.
  - Go to CHECK.
- CHECK: o_start_check = 1 and o_second_check = second_r, both registered. They rise the cycle after EVAL and are held stable while in CHECK.
  - On i_done_check: next cycle o_start_check = 0, o_second_check = 0, state IDLE.
  - Timeout counter clears on CHECK entry. If it reaches TIMEOUT_CYC-1 without i_done_check: pulse o_timeout for 1 cycle, drop start/second, go to IDLE.
  - If i_done_check and the timeout occur in the same cycle, done wins and no o_timeout is issued.
- o_Functional_Lanes and o_lane_pass hold their values after CHECK until the next EVAL. The checker compares the second-pass code against the first.
- i_abort: from any state, go to IDLE next cycle and deassert o_start_check/o_second_check. Counters are untouched until the next start. Result outputs hold. i_abort has priority over every other input.
- Latency: i_pattern_done at cycle N gives results valid and o_start_check high at N+2.
- Async reset mid-operation returns every output immediately to its reset value.

Test Plan:
1. First pass, no errors: start_eval with second_pass = 0, 20 valid cycles with i_lane_err = 0, pattern_done -> two cycles later o_Functional_Lanes = 11, o_lane_pass = FFFF, o_start_check = 1, o_second_check = 0. Done_check one cycle later -> o_start_check = 0 and state IDLE on the next cycle.
2. Upper-half failure: lane 12 flagged on 5 valid cycles with threshold 4 -> o_lane_pass = EFFF, o_Functional_Lanes = 01. Lane 3 flagged 5 times instead -> FFF7, code 10.
3. Boundary and saturation: lane 0 flagged exactly 4 times -> still passes, code 11. Lane 0 flagged 300 times with CNT_W = 8 -> counter stays at 255 (no wrap), lane fails, code 10.
4. Second pass and edge timing: start_eval with second_pass = 1 -> o_second_check = 1 while in CHECK. Error sample coincident with pattern_done is counted (lane 1 with 4 prior errors plus 1 coincident -> fails).
5. Timeout and collision: no done_check -> o_timeout pulses exactly at cycle TIMEOUT_CYC of CHECK and the block returns to IDLE. Done_check on the same cycle as the timeout -> no o_timeout pulse.
6. Abort and reset: i_abort during ACCUM -> IDLE and o_busy = 0 next cycle. rst_n low during CHECK -> all outputs 0 immediately. i_start_eval in ACCUM -> ignored, counts preserved.

Source files
------------

// File: rtl/repairmb_lane_evaluator.sv
// RepairMB lane evaluator: accumulates per-lane compare errors, thresholds them into the
// 2-bit functional-lane code, then runs the start/second-check handshake with a timeout.
module repairmb_lane_evaluator #(
    parameter int NUM_LANES     = 16,
    parameter int CNT_W         = 8,
    parameter int ERR_THRESHOLD = 4,
    parameter int TIMEOUT_CYC   = 1024
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic                 i_start_eval,
    input  logic                 i_second_pass,
    input  logic                 i_lane_err_valid,
    input  logic [NUM_LANES-1:0] i_lane_err,
    input  logic                 i_pattern_done,
    input  logic                 i_done_check,
    input  logic                 i_abort,
    output logic [1:0]           o_Functional_Lanes,
    output logic [NUM_LANES-1:0] o_lane_pass,
    output logic                 o_start_check,
    output logic                 o_second_check,
    output logic                 o_busy,
    output logic                 o_timeout
);

    localparam int HALF  = NUM_LANES / 2;
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] THRESH   = CNT_W'(ERR_THRESHOLD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EVAL  = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   err_cnt [NUM_LANES];
    logic [TMO_W-1:0]   tmo_cnt;
    logic               second_r;
    logic [NUM_LANES-1:0] lane_ok;

    always_comb begin
        lane_ok = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_ok[i] = (err_cnt[i] <= THRESH);
        end
    end

    assign o_busy = (state != IDLE);

    // Abort is checked ahead of the state case so it overrides every other input.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            for (int i = 0; i < NUM_LANES; i++) begin
                err_cnt[i] <= '0;
            end
            tmo_cnt            <= '0;
            second_r           <= 1'b0;
            o_Functional_Lanes <= 2'b00;
            o_lane_pass        <= '0;
            o_start_check      <= 1'b0;
            o_second_check     <= 1'b0;
            o_timeout          <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            if (i_abort) begin
                state          <= IDLE;
                o_start_check  <= 1'b0;
                o_second_check <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_start_eval) begin
                            for (int i = 0; i < NUM_LANES; i++) begin
                                err_cnt[i] <= '0;
                            end
                            second_r <= i_second_pass;
                            state    <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (i_lane_err_valid) begin
                            for (int i = 0; i < NUM_LANES; i++) begin
                                if (i_lane_err[i] && (err_cnt[i] != '1)) begin
                                    err_cnt[i] <= err_cnt[i] + 1'b1;
                                end
                            end
                        end
                        if (i_pattern_done) begin
                            state <= EVAL;
                        end
                    end
                    EVAL: begin
                        o_lane_pass        <= lane_ok;
                        o_Functional_Lanes <= {&lane_ok[NUM_LANES-1:HALF], &lane_ok[HALF-1:0]};
                        o_start_check      <= 1'b1;
                        o_second_check     <= second_r;
                        tmo_cnt            <= '0;
                        state              <= CHECK;
                    end
                    CHECK: begin
                        if (i_done_check) begin
                            o_start_check  <= 1'b0;
                            o_second_check <= 1'b0;
                            state          <= IDLE;
                        end else if (tmo_cnt == TMO_LAST) begin
                            o_timeout      <= 1'b1;
                            o_start_check  <= 1'b0;
                            o_second_check <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
